// File: rtl/alu_sequencer.sv
// Command sequencer for an external combinational signed ALU: accepts one command,
// drives the ALU for a single EXEC cycle, then holds the response until it is taken.
module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_ovf,
    output logic             rsp_err
);

    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    localparam logic [1:0] CTRL_ADD = 2'b00;
    localparam logic [1:0] CTRL_SUB = 2'b01;
    localparam logic [1:0] CTRL_AND = 2'b10;
    localparam logic [1:0] CTRL_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [1:0]       alu_ctrl_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;
    logic             err_q;

    logic [WIDTH-1:0] acc_d;
    logic             ovf_d;
    logic             flags_upd_d;

    function automatic logic [1:0] op_to_ctrl(input logic [2:0] op);
        case (op)
            OP_ADD:  op_to_ctrl = CTRL_ADD;
            OP_SUB:  op_to_ctrl = CTRL_SUB;
            OP_AND:  op_to_ctrl = CTRL_AND;
            OP_OR:   op_to_ctrl = CTRL_OR;
            default: op_to_ctrl = CTRL_ADD;
        endcase
    endfunction

    // Result of the command in EXEC; only consumed on the EXEC -> RESP edge.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        acc_d       = acc_q;
        ovf_d       = 1'b0;
        flags_upd_d = 1'b0;
        case (op_q)
            OP_LOAD: begin
                acc_d       = data_q;
                flags_upd_d = 1'b1;
            end
            OP_ADD: begin
                acc_d       = alu_result;
                flags_upd_d = 1'b1;
                ovf_d       = (acc_q[MSB] == data_q[MSB]) && (alu_result[MSB] != acc_q[MSB]);
            end
            OP_SUB: begin
                acc_d       = alu_result;
                flags_upd_d = 1'b1;
                ovf_d       = (acc_q[MSB] != data_q[MSB]) && (alu_result[MSB] != acc_q[MSB]);
            end
            OP_AND, OP_OR: begin
                acc_d       = alu_result;
                flags_upd_d = 1'b1;
            end
            OP_CLR: begin
                acc_d       = '0;
                flags_upd_d = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_NOP;
            data_q      <= '0;
            acc_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= CTRL_ADD;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= cmd_op;
                        data_q      <= cmd_data;
                        alu_a_q     <= acc_q;
                        alu_b_q     <= cmd_data;
                        alu_ctrl_q  <= op_to_ctrl(cmd_op);
                        cmd_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    acc_q       <= acc_d;
                    rsp_data_q  <= acc_d;
                    err_q       <= (op_q == OP_RSV);
                    if (flags_upd_d) begin
                        zero_q <= (acc_d == '0);
                        neg_q  <= acc_d[MSB];
                        ovf_q  <= ovf_d;
                    end
                    alu_ctrl_q  <= CTRL_ADD;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctrl_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_zero    = zero_q;
    assign rsp_neg     = neg_q;
    assign rsp_ovf     = ovf_q;
    assign rsp_err     = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: integer-arithmetic reference model, a per-cycle compare
// process on the falling edge, and literal expectations for the directed vectors.
module tb_alu_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_control;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic       rsp_neg;
    logic       rsp_ovf;
    logic       rsp_err;

    alu_sequencer #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero),
        .rsp_neg     (rsp_neg),
        .rsp_ovf     (rsp_ovf),
        .rsp_err     (rsp_err)
    );

    // Downstream combinational ALU.
    always_comb begin
        alu_result = alu_a + alu_b;
        case (alu_control)
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            2'b11:   alu_result = alu_a | alu_b;
            default: alu_result = alu_a + alu_b;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [7:0] m_acc;
    logic       m_zero, m_neg, m_ovf, m_err;

    // Expected outputs for the current cycle, maintained by the driver.
    logic       chk_en;
    logic       rsp_chk;
    logic       exp_ready, exp_valid;
    logic [7:0] exp_a, exp_b, exp_data;
    logic [1:0] exp_ctrl;

    // DUT samples captured by the driver for literal checks.
    logic [7:0] got_a, got_b, got_data;
    logic [1:0] got_ctrl;
    logic       got_zero, got_neg, got_ovf, got_err;

    function automatic logic [1:0] ctrl_of(input logic [2:0] op);
        case (op)
            3'd2:    return 2'b00;
            3'd3:    return 2'b01;
            3'd4:    return 2'b10;
            3'd5:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_apply(input logic [2:0] op, input logic [7:0] d);
        int a_i, b_i, s;
        bit upd;
        a_i = int'($signed(m_acc));
        b_i = int'($signed(d));
        upd = 1'b1;
        case (op)
            3'd1: begin m_acc = d;           m_ovf = 1'b0; end
            3'd2: begin s = a_i + b_i; m_acc = s[7:0]; m_ovf = (s > 127) || (s < -128); end
            3'd3: begin s = a_i - b_i; m_acc = s[7:0]; m_ovf = (s > 127) || (s < -128); end
            3'd4: begin m_acc = m_acc & d;   m_ovf = 1'b0; end
            3'd5: begin m_acc = m_acc | d;   m_ovf = 1'b0; end
            3'd6: begin m_acc = 8'd0;        m_ovf = 1'b0; end
            default: upd = 1'b0;
        endcase
        if (upd) begin
            m_zero = (int'($signed(m_acc)) == 0);
            m_neg  = (int'($signed(m_acc)) < 0);
        end
        m_err = (op == 3'd7);
    endtask

    // Single compare process: checks every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready",   8'(cmd_ready),   8'(exp_ready));
            check("rsp_valid",   8'(rsp_valid),   8'(exp_valid));
            check("alu_a",       alu_a,           exp_a);
            check("alu_b",       alu_b,           exp_b);
            check("alu_control", 8'(alu_control), 8'(exp_ctrl));
            if (exp_valid || rsp_chk) begin
                check("rsp_data", rsp_data,      exp_data);
                check("rsp_zero", 8'(rsp_zero),  8'(m_zero));
                check("rsp_neg",  8'(rsp_neg),   8'(m_neg));
                check("rsp_ovf",  8'(rsp_ovf),   8'(m_ovf));
                check("rsp_err",  8'(rsp_err),   8'(m_err));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full command from IDLE back to IDLE; during a stall a competing command
    // is held on the input and must be ignored.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, input int stall);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
        rsp_chk   = 1'b0;
        exp_ready = 1'b0;
        exp_a     = m_acc;
        exp_b     = d;
        exp_ctrl  = ctrl_of(op);
        got_a     = alu_a;
        got_b     = alu_b;
        got_ctrl  = alu_control;
        model_apply(op, d);
        step();
        exp_ctrl  = 2'b00;
        exp_valid = 1'b1;
        exp_data  = m_acc;
        got_data  = rsp_data;
        got_zero  = rsp_zero;
        got_neg   = rsp_neg;
        got_ovf   = rsp_ovf;
        got_err   = rsp_err;
        if (stall > 0) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            cmd_op    = 3'd1;
            cmd_data  = 8'h55;
            repeat (stall) step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        exp_valid = 1'b0;
        exp_ready = 1'b1;
    endtask

    initial begin
        chk_en    = 1'b0;
        rsp_chk   = 1'b0;
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_data  = 8'h11;
        rsp_ready = 1'b0;
        m_acc = 8'd0; m_zero = 1'b0; m_neg = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
        exp_ready = 1'b1; exp_valid = 1'b0;
        exp_a = 8'd0; exp_b = 8'd0; exp_data = 8'd0; exp_ctrl = 2'b00;

        // Reset wins over a simultaneous command.
        repeat (2) step();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        chk_en    = 1'b1;
        rsp_chk   = 1'b1;
        step();

        // LOAD 100, ADD 50: signed overflow to -106.
        run_cmd(3'd1, 8'd100, 0);
        run_cmd(3'd2, 8'd50, 0);
        check("add_exec_a",    got_a,          8'h64);
        check("add_exec_b",    got_b,          8'h32);
        check("add_exec_ctrl", 8'(got_ctrl),   8'h00);
        check("add_data",      got_data,       8'h96);
        check("add_ovf",       8'(got_ovf),    8'h01);
        check("add_neg",       8'(got_neg),    8'h01);
        check("add_zero",      8'(got_zero),   8'h00);

        // LOAD -128, SUB 1 -> 127 with overflow.
        run_cmd(3'd1, 8'h80, 0);
        run_cmd(3'd3, 8'd1, 0);
        check("sub_ctrl", 8'(got_ctrl), 8'h01);
        check("sub_data", got_data,     8'h7F);
        check("sub_ovf",  8'(got_ovf),  8'h01);
        check("sub_neg",  8'(got_neg),  8'h00);

        // LOAD 5, SUB 5 -> 0.
        run_cmd(3'd1, 8'd5, 0);
        run_cmd(3'd3, 8'd5, 0);
        check("sub0_data", got_data,    8'h00);
        check("sub0_zero", 8'(got_zero), 8'h01);
        check("sub0_ovf",  8'(got_ovf),  8'h00);

        // LOAD 0x0F, OR 0xF0, AND 0x00.
        run_cmd(3'd1, 8'h0F, 0);
        run_cmd(3'd5, 8'hF0, 0);
        check("or_ctrl", 8'(got_ctrl), 8'h03);
        check("or_data", got_data,     8'hFF);
        check("or_neg",  8'(got_neg),  8'h01);
        run_cmd(3'd4, 8'h00, 0);
        check("and_ctrl", 8'(got_ctrl), 8'h02);
        check("and_data", got_data,     8'h00);
        check("and_zero", 8'(got_zero), 8'h01);
        check("and_ovf",  8'(got_ovf),  8'h00);

        // -128 - 121 wraps to 7 with overflow; then reserved and NOP keep flags.
        run_cmd(3'd1, 8'h80, 0);
        run_cmd(3'd3, 8'd121, 0);
        check("wrap7_data", got_data,   8'h07);
        check("wrap7_ovf",  8'(got_ovf), 8'h01);
        run_cmd(3'd7, 8'h33, 0);
        check("rsv_data", got_data,     8'h07);
        check("rsv_err",  8'(got_err),  8'h01);
        check("rsv_ovf",  8'(got_ovf),  8'h01);
        run_cmd(3'd0, 8'h44, 0);
        check("nop_data", got_data,     8'h07);
        check("nop_err",  8'(got_err),  8'h00);
        check("nop_ovf",  8'(got_ovf),  8'h01);

        // Response stalled for 5 cycles with a competing command pending.
        run_cmd(3'd2, 8'd1, 5);
        check("stall_data", got_data, 8'h08);

        run_cmd(3'd6, 8'h99, 0);
        check("clr_zero", 8'(got_zero), 8'h01);

        // Reset during EXEC of ADD aborts the command.
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_data  = 8'd9;
        run_cmd(3'd1, 8'd20, 0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_data  = 8'd9;
        step();
        cmd_valid = 1'b0;
        exp_ready = 1'b0;
        exp_a     = m_acc;
        exp_b     = 8'd9;
        exp_ctrl  = 2'b00;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        m_acc = 8'd0; m_zero = 1'b0; m_neg = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
        exp_ready = 1'b1; exp_valid = 1'b0;
        exp_a = 8'd0; exp_b = 8'd0; exp_data = 8'd0; exp_ctrl = 2'b00;
        rsp_chk = 1'b1;
        step();
        run_cmd(3'd2, 8'd3, 0);
        check("post_reset_data", got_data,    8'h03);
        check("post_reset_a",    got_a,       8'h00);

        // -1 + 1 wraps to zero without overflow.
        run_cmd(3'd1, 8'hFF, 0);
        run_cmd(3'd2, 8'd1, 0);
        check("wrap0_data", got_data,     8'h00);
        check("wrap0_zero", 8'(got_zero), 8'h01);
        check("wrap0_ovf",  8'(got_ovf),  8'h00);

        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
